mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have inputs: op  in  6  opcode of latched IR; funct  in  6  R-type function field; zero  in  1  ALU zero flag; sign  in  1  ALU sign flag; mem_ready  in  1  memory access complete.
REQ-003 SHALL have outputs: PCWrite 1; IRWrite 1; mem_req 1; mWR 1; Regwrite 1; RegDst 1; ExtSel 1; ALUsrcA 1; ALUsrcB 1; datasrc 1; pcsrc 2; ALUop 4; halt 1; state 3 (current state, debug).

Function
REQ-004 SHALL be a Moore/Mealy FSM with states IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to IF.
REQ-005 IF: mem_req=1; on mem_ready=1 SHALL pulse IRWrite=1 and PCWrite=1 with pcsrc=0 (PC+4) and go to ID; else stay IF with both strobes 0.
REQ-006 ID: j (000010) SHALL assert PCWrite=1, pcsrc=2, go IF; 111111 SHALL go HALT; undefined opcode SHALL be a NOP (go IF, no strobes); all others go EXE.
REQ-007 EXE drives ALUop/ALUsrcA/ALUsrcB/ExtSel per REQ-008; branches SHALL assert PCWrite=pcsrc[0]=taken, pcsrc=1, then go IF; sw/lw go MEM; all others go WB.
REQ-008 ALU encoding: sll ALUop=0111 ALUsrcA=1; add 0100, sub 0101, and 0000, or 0001 (R-type, ALUsrcB=0, RegDst=1); undefined funct SHALL be treated as or; addiu 0100 ExtSel=1; andi 0000 ExtSel=0; ori 0001 ExtSel=0; slti 0110 ExtSel=1; lw/sw 0100 ExtSel=1 ALUsrcB=1; beq/bne/bltz 0101 ExtSel=1 ALUsrcB=0.
REQ-009 taken = (beq & zero) | (bne & ~zero) | (bltz & sign), sampled in EXE same cycle.
REQ-010 MEM: mem_req=1, mWR=1 for sw; on mem_ready sw SHALL go IF, lw SHALL go WB; while mem_ready=0 SHALL hold with mWR held.
REQ-011 WB: Regwrite=1 for exactly one cycle; datasrc=1 for lw else 0; RegDst=1 for R-type else 0; then IF.
REQ-012 Cycle counts with mem_ready always 1: j/NOP 2, branch 3, R/I-arith 4, sw 4, lw 5.
REQ-013 HALT: halt=1, all strobes 0, SHALL remain until rst_n low.
REQ-014 Outside the state that uses them, PCWrite, IRWrite, mem_req, mWR, Regwrite SHALL be 0; datapath selects SHALL be held stable from EXE through WB.
REQ-015 op/funct SHALL be sampled only in ID..WB (IR stable); IF SHALL ignore them.

Reset
REQ-016 rst_n=0 SHALL immediately force state=IF and all outputs 0 (pcsrc=00, ALUop=0000), including mid-instruction; no strobe SHALL glitch high during reset.
REQ-017 First rising clk after rst_n deassertion SHALL evaluate IF with mem_req=1.

Configuration
REQ-018 Macro MC_MEM_WAIT_EN defined: IF and MEM wait on mem_ready per REQ-005/010.
REQ-019 MC_MEM_WAIT_EN undefined: mem_ready SHALL be ignored (treated as 1); IF and MEM each last exactly one cycle; port SHALL remain present.

Structure
REQ-020 Shared package mc_pkg SHALL hold state encoding, opcode/funct constants and ALUop codes; ALU and datapath SHALL import the same ALUop constants.
REQ-021 Sub-module mc_decode SHALL combinationally map op/funct to instruction class and ALU controls; mc_control_fsm SHALL own only state register and strobe timing.

Verification
REQ-022 add (op=0, funct=100000), mem_ready=1 -> states IF,ID,EXE,WB; ALUop=0100; Regwrite=1 in cycle 4 only; RegDst=1.
REQ-023 lw (100011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, WB with datasrc=1, Regwrite=1; total 8 cycles.
REQ-024 beq with zero=1 -> EXE PCWrite=1 pcsrc=1; zero=0 -> PCWrite=0; bltz sign=1 -> taken; bne zero=1 -> not taken.
REQ-025 j (000010) -> ID PCWrite=1 pcsrc=2, back to IF in 2 cycles; op=111111 -> HALT, halt=1 held 20 cycles, exits only on rst_n.
REQ-026 rst_n pulsed low in MEM of sw -> mWR drops same cycle asynchronously, state=IF, no further strobes; with MC_MEM_WAIT_EN undefined, mem_ready=0 -> lw still 5 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared control definitions: state encoding, opcode/funct values, ALU op codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // ALU op codes, shared with the ALU and datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  typedef enum logic [2:0] {
    CL_NOP, CL_R, CL_I, CL_LW, CL_SW, CL_BR, CL_J, CL_HALT
  } iclass_e;

  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_LTZ} br_e;

  typedef struct packed {
    iclass_e    cls;
    br_e        br;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic       reg_dst;
    logic       data_src;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Maps opcode/funct of the latched IR to instruction class and ALU/datapath selects.
// Latency: purely combinational.
// Backpressure: none; output follows IR.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  // Opcode/funct decode; unknown opcodes become NOPs, unknown funct behaves as or
  always_comb begin
    ctrl     = '0;
    ctrl.cls = CL_NOP;
    ctrl.br  = BR_NONE;
    case (op)
      OP_RTYPE: begin
        ctrl.cls     = CL_R;
        ctrl.reg_dst = 1'b1;
        case (funct)
          FN_SLL: begin
            ctrl.alu_op    = ALU_SLL;
            ctrl.alu_src_a = 1'b1;
          end
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_OR;
        endcase
      end
      OP_ADDIU, OP_SLTI: begin
        ctrl.cls       = CL_I;
        ctrl.alu_op    = (op == OP_ADDIU) ? ALU_ADD : ALU_SLT;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.cls       = CL_I;
        ctrl.alu_op    = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        ctrl.alu_src_b = 1'b1;
      end
      OP_LW, OP_SW: begin
        ctrl.cls       = (op == OP_LW) ? CL_LW : CL_SW;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
        ctrl.data_src  = (op == OP_LW);
      end
      OP_BEQ, OP_BNE, OP_BLTZ: begin
        ctrl.cls     = CL_BR;
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
        ctrl.br      = (op == OP_BEQ) ? BR_EQ : ((op == OP_BNE) ? BR_NE : BR_LTZ);
      end
      OP_J:    ctrl.cls = CL_J;
      OP_HALT: ctrl.cls = CL_HALT;
      default: ctrl.cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control: IF/ID/EXE/MEM/WB/HALT state register and strobe timing.
// Latency: 2..5 cycles per instruction; MC_MEM_WAIT_EN makes IF/MEM stall on mem_ready.
// Backpressure: without MC_MEM_WAIT_EN mem_ready is ignored; reset forces all outputs to 0.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       mem_req,
  output logic       mWR,
  output logic       Regwrite,
  output logic       RegDst,
  output logic       ExtSel,
  output logic       ALUsrcA,
  output logic       ALUsrcB,
  output logic       datasrc,
  output logic [1:0] pcsrc,
  output logic [3:0] ALUop,
  output logic       halt,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic       mem_rdy;
  logic       taken;
  logic       pc_write_c, ir_write_c, mem_req_c, m_wr_c, reg_write_c, halt_c, sel_en_c;
  logic [1:0] pcsrc_c;

`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign mem_rdy          = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  assign taken = ((ctrl.br == BR_EQ)  &  zero) |
                 ((ctrl.br == BR_NE)  & ~zero) |
                 ((ctrl.br == BR_LTZ) &  sign);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Next-state and strobe generation; decode is only consulted from ID onwards
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_req_c   = 1'b0;
    m_wr_c      = 1'b0;
    reg_write_c = 1'b0;
    halt_c      = 1'b0;
    sel_en_c    = 1'b0;
    pcsrc_c     = 2'd0;
    case (state_q)
      ST_IF: begin
        mem_req_c = 1'b1;
        if (mem_rdy) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_ID;
        end
      end
      ST_ID: begin
        case (ctrl.cls)
          CL_J: begin
            pc_write_c = 1'b1;
            pcsrc_c    = 2'd2;
            state_d    = ST_IF;
          end
          CL_HALT: state_d = ST_HALT;
          CL_NOP:  state_d = ST_IF;
          default: state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        sel_en_c = 1'b1;
        if (ctrl.cls == CL_BR) begin
          pcsrc_c    = 2'd1;
          pc_write_c = taken;
          state_d    = ST_IF;
        end else if (ctrl.cls == CL_LW || ctrl.cls == CL_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        sel_en_c  = 1'b1;
        mem_req_c = 1'b1;
        m_wr_c    = (ctrl.cls == CL_SW);
        if (mem_rdy) state_d = (ctrl.cls == CL_SW) ? ST_IF : ST_WB;
      end
      ST_WB: begin
        sel_en_c    = 1'b1;
        reg_write_c = 1'b1;
        state_d     = ST_IF;
      end
      ST_HALT: halt_c = 1'b1;
      default: state_d = ST_IF;
    endcase
  end

  // Reset gates every output combinationally so nothing glitches while rst_n is low
  assign PCWrite  = rst_n & pc_write_c;
  assign IRWrite  = rst_n & ir_write_c;
  assign mem_req  = rst_n & mem_req_c;
  assign mWR      = rst_n & m_wr_c;
  assign Regwrite = rst_n & reg_write_c;
  assign halt     = rst_n & halt_c;
  assign pcsrc    = rst_n ? pcsrc_c : 2'd0;
  assign RegDst   = rst_n & sel_en_c & ctrl.reg_dst;
  assign ExtSel   = rst_n & sel_en_c & ctrl.ext_sel;
  assign ALUsrcA  = rst_n & sel_en_c & ctrl.alu_src_a;
  assign ALUsrcB  = rst_n & sel_en_c & ctrl.alu_src_b;
  assign datasrc  = rst_n & sel_en_c & ctrl.data_src;
  assign ALUop    = (rst_n && sel_en_c) ? ctrl.alu_op : 4'd0;
  assign state    = rst_n ? state_q : ST_IF;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed checks of the multicycle control FSM against hand-computed values.
// Latency: checks sampled 1 time unit after each falling clock edge.
// Backpressure: mem_ready is held low in MEM to exercise the wait path where enabled.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IRWrite, mem_req, mWR, Regwrite, RegDst, ExtSel;
  logic       ALUsrcA, ALUsrcB, datasrc, halt;
  logic [1:0] pcsrc;
  logic [3:0] ALUop;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .sign     (sign),
    .mem_ready(mem_ready),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .mem_req  (mem_req),
    .mWR      (mWR),
    .Regwrite (Regwrite),
    .RegDst   (RegDst),
    .ExtSel   (ExtSel),
    .ALUsrcA  (ALUsrcA),
    .ALUsrcB  (ALUsrcB),
    .datasrc  (datasrc),
    .pcsrc    (pcsrc),
    .ALUop    (ALUop),
    .halt     (halt),
    .state    (state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl_word();
    return 32'({ALUop, ALUsrcA, ALUsrcB, ExtSel, RegDst});
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({PCWrite, IRWrite, mem_req, mWR, Regwrite});
  endfunction

  // From IF, load the instruction and advance to EXE (two cycles)
  task automatic to_exe(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
    tick();
    tick();
  endtask

  // Step until back in IF; counts MEM cycles and WB behaviour on the way
  task automatic run_to_if(input int mem_wait, output int n, output int mem_n,
                           output int wb_rw, output logic wb_ds);
    int w;
    w     = 0;
    n     = 0;
    mem_n = 0;
    wb_rw = 0;
    wb_ds = 1'b0;
    do begin
      if (state == 3'd3) mem_n++;
      if (state == 3'd4) begin
        wb_rw += int'(Regwrite);
        wb_ds = datasrc;
      end
      if (state == 3'd3 && w < mem_wait) begin
        mem_ready = 1'b0;
        w++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      tick();
      n++;
    end while (state != 3'd0 && n < 40);
    mem_ready = 1'b1;
  endtask

  task automatic alu_case(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic [31:0] exp_ctl);
    int n, mn, rw;
    logic ds;
    to_exe(o, f);
    check_val({tag, "_ctl"}, ctl_word(), exp_ctl);
    run_to_if(0, n, mn, rw, ds);
    check_val({tag, "_cycles"}, 32'(n + 2), 4);
  endtask

  task automatic br_case(input string tag, input logic [5:0] o, input logic z, input logic s,
                         input logic [31:0] exp_taken);
    int n, mn, rw;
    logic ds;
    to_exe(o, 6'd0);
    zero = z;
    sign = s;
    #1;
    check_val({tag, "_pcwrite"}, 32'(PCWrite), exp_taken);
    check_val({tag, "_pcsrc"}, 32'(pcsrc), 1);
    check_val({tag, "_ctl"}, ctl_word(), 'h52);
    run_to_if(0, n, mn, rw, ds);
    check_val({tag, "_cycles"}, 32'(n + 2), 3);
    zero = 1'b0;
    sign = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, mn, rw, ok;
    logic ds;

    // Reset state
    tick();
    check_val("rst_state", 32'(state), 0);
    check_val("rst_strobes", strobes(), 0);
    check_val("rst_aluop", 32'(ALUop), 0);
    check_val("rst_pcsrc", 32'(pcsrc), 0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_memreq", 32'(mem_req), 1);

    // add: IF,ID,EXE,WB with strobes in the right cycles
    op    = 6'b000000;
    funct = 6'b100000;
    check_val("add_if_strobes", strobes(), 'b11100);
    tick();
    check_val("add_id_state", 32'(state), 1);
    check_val("add_id_strobes", strobes(), 0);
    tick();
    check_val("add_exe_state", 32'(state), 2);
    check_val("add_exe_ctl", ctl_word(), 'h41);
    check_val("add_exe_regwrite", 32'(Regwrite), 0);
    tick();
    check_val("add_wb_state", 32'(state), 4);
    check_val("add_wb_regwrite", 32'(Regwrite), 1);
    check_val("add_wb_regdst", 32'(RegDst), 1);
    check_val("add_wb_datasrc", 32'(datasrc), 0);
    tick();
    check_val("add_back_if", 32'(state), 0);
    check_val("add_if_regwrite", 32'(Regwrite), 0);

    // ALU encodings: {ALUop, ALUsrcA, ALUsrcB, ExtSel, RegDst}
    alu_case("sll",   6'b000000, 6'b000000, 'h79);
    alu_case("sub",   6'b000000, 6'b100010, 'h51);
    alu_case("and",   6'b000000, 6'b100100, 'h01);
    alu_case("badfn", 6'b000000, 6'b111000, 'h11);
    alu_case("addiu", 6'b001001, 6'b000000, 'h46);
    alu_case("andi",  6'b001100, 6'b000000, 'h04);
    alu_case("ori",   6'b001101, 6'b000000, 'h14);
    alu_case("slti",  6'b001010, 6'b000000, 'h66);

    // Branches
    br_case("beq_z1",  6'b000100, 1'b1, 1'b0, 1);
    br_case("beq_z0",  6'b000100, 1'b0, 1'b0, 0);
    br_case("bltz_s1", 6'b000001, 1'b0, 1'b1, 1);
    br_case("bltz_s0", 6'b000001, 1'b1, 1'b0, 0);
    br_case("bne_z1",  6'b000101, 1'b1, 1'b0, 0);
    br_case("bne_z0",  6'b000101, 1'b0, 1'b0, 1);

    // j: PCWrite with pcsrc=2 in ID, back to IF after 2 cycles
    op = 6'b000010;
    tick();
    check_val("j_id_pcwrite", 32'(PCWrite), 1);
    check_val("j_id_pcsrc", 32'(pcsrc), 2);
    tick();
    check_val("j_back_if", 32'(state), 0);

    // Undefined opcode behaves as NOP
    op = 6'b010000;
    tick();
    check_val("nop_id_strobes", strobes(), 0);
    tick();
    check_val("nop_back_if", 32'(state), 0);

    // sw: MEM writes, 4 cycles
    to_exe(6'b101011, 6'd0);
    check_val("sw_exe_ctl", ctl_word(), 'h46);
    tick();
    check_val("sw_mem_state", 32'(state), 3);
    check_val("sw_mem_strobes", strobes(), 'b00110);
    tick();
    check_val("sw_back_if", 32'(state), 0);

    // lw with mem_ready low for 3 cycles in MEM
    to_exe(6'b100011, 6'd0);
    check_val("lw_exe_ctl", ctl_word(), 'h46);
    run_to_if(3, n, mn, rw, ds);
`ifdef MC_MEM_WAIT_EN
    check_val("lw_mem_cycles", 32'(mn), 4);
    check_val("lw_total_cycles", 32'(n + 2), 8);
`else
    check_val("lw_mem_cycles", 32'(mn), 1);
    check_val("lw_total_cycles", 32'(n + 2), 5);
`endif
    check_val("lw_wb_regwrite", 32'(rw), 1);
    check_val("lw_wb_datasrc", 32'(ds), 1);

    // Reset asserted in MEM of sw
    to_exe(6'b101011, 6'd0);
    tick();
    check_val("swrst_pre_mwr", 32'(mWR), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("swrst_mwr_async", 32'(mWR), 0);
    check_val("swrst_state", 32'(state), 0);
    tick();
    check_val("swrst_strobes", strobes(), 0);
    rst_n = 1'b1;
    #1;
    check_val("swrst_release_if", 32'({state, mem_req}), 1);

    // HALT held for 20 cycles, exits only through reset
    op = 6'b111111;
    tick();
    tick();
    check_val("halt_state", 32'(state), 5);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halt === 1'b1 && state === 3'd5 && strobes() === 32'd0) ok++;
    end
    check_val("halt_hold", 32'(ok), 20);
    rst_n = 1'b0;
    #1;
    check_val("halt_rst", 32'({halt, state}), 0);
    tick();
    rst_n = 1'b1;
    op    = 6'd0;
    #1;
    check_val("halt_exit_if", 32'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
